// File: rtl/alu_core_nbit.sv
// alu_core_nbit: N-bit multi-cycle ALU (clk, rst, start/op/a/b/cin in; result, result_hi, flag_n/z/c/v, err, busy, done out)
module alu_core_nbit #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] result,
  output logic [N-1:0] result_hi,
  output logic         flag_n,
  output logic         flag_z,
  output logic         flag_c,
  output logic         flag_v,
  output logic         err,
  output logic         busy,
  output logic         done
);
  localparam int CW = $clog2(N);
  localparam logic [N-1:0] NB = N'(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, result_q, result_d, result_hi_q, result_hi_d;
  logic cin_q, cin_d, n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d, err_q, err_d;
  logic [2*N-1:0] sh_q, sh_d, p_q, p_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0] add_w, sub_w, div_r, shl_w, shr_w;
  logic [N-1:0] div_rn, r_x, rh_x;
  logic [2*N-1:0] mul_p, div_p;
  logic div_ge, c_x, v_x, e_x, upd, last;
  always_comb begin
    add_w = {1'b0, a_q} + {1'b0, b_q} + {{N{1'b0}}, cin_q};
    sub_w = {1'b0, a_q} - {1'b0, b_q};
    mul_p = p_q + (b_q[0] ? sh_q : '0);
    div_r = {p_q[2*N-1:N], a_q[N-1]};
    div_ge = div_r >= {1'b0, b_q};
    div_rn = div_ge ? div_r[N-1:0] - b_q : div_r[N-1:0];
    div_p = {div_rn, p_q[N-2:0], div_ge};
    shl_w = {1'b0, a_q} << b_q;
    shr_w = {a_q, 1'b0} >> b_q;
    last = cnt_q == LAST;
    r_x = '0;
    rh_x = '0;
    c_x = 1'b0;
    v_x = 1'b0;
    e_x = 1'b0;
    case (op_q)
      4'd0: begin
        r_x = add_w[N-1:0];
        c_x = add_w[N];
        v_x = (a_q[N-1] == b_q[N-1]) && (add_w[N-1] != a_q[N-1]);
      end
      4'd1: begin
        r_x = sub_w[N-1:0];
        c_x = sub_w[N];
        v_x = (a_q[N-1] != b_q[N-1]) && (sub_w[N-1] != a_q[N-1]);
      end
      4'd2: begin
        {rh_x, r_x} = mul_p;
        c_x = |mul_p[2*N-1:N];
        v_x = c_x;
      end
      4'd3: begin
        {rh_x, r_x} = div_p;
        e_x = b_q == '0;
      end
      4'd4: begin
        r_x = (b_q == '0) ? a_q : a_q % b_q;
        e_x = b_q == '0;
      end
      4'd5: r_x = a_q & b_q;
      4'd6: r_x = a_q | b_q;
      4'd7: r_x = a_q ^ b_q;
      4'd8: begin
        r_x = shl_w[N-1:0];
        c_x = (b_q == NB) ? a_q[N-1] : (b_q == '0 || b_q > NB) ? 1'b0 : shl_w[N];
      end
      4'd9: begin
        r_x = shr_w[N:1];
        c_x = (b_q == NB) ? a_q[0] : (b_q == '0 || b_q > NB) ? 1'b0 : shr_w[0];
      end
      default: e_x = 1'b1;
    endcase
    upd = state_q == EXEC || (state_q == ITER && last);
    state_d = state_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    cin_d = cin_q;
    sh_d = sh_q;
    p_d = p_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && start) begin
      state_d = (op == 4'd2 || op == 4'd3) ? ITER : EXEC;
      op_d = op;
      a_d = a;
      b_d = b;
      cin_d = cin;
      sh_d = {{N{1'b0}}, a};
      p_d = '0;
      cnt_d = '0;
    end else if (state_q == ITER) begin
      state_d = last ? DONE : ITER;
      p_d = (op_q == 4'd2) ? mul_p : div_p;
      sh_d = sh_q << 1;
      a_d = a_q << 1;
      b_d = (op_q == 4'd2) ? b_q >> 1 : b_q;
      cnt_d = cnt_q + CW'(1);
    end else if (state_q == EXEC) begin
      state_d = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    result_d = upd ? r_x : result_q;
    result_hi_d = upd ? rh_x : result_hi_q;
    n_d = upd ? r_x[N-1] : n_q;
    z_d = upd ? r_x == '0 : z_q;
    c_d = upd ? c_x : c_q;
    v_d = upd ? v_x : v_q;
    err_d = upd ? e_x : err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      cin_q <= 1'b0;
      sh_q <= '0;
      p_q <= '0;
      cnt_q <= '0;
      result_q <= '0;
      result_hi_q <= '0;
      n_q <= 1'b0;
      z_q <= 1'b0;
      c_q <= 1'b0;
      v_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      cin_q <= cin_d;
      sh_q <= sh_d;
      p_q <= p_d;
      cnt_q <= cnt_d;
      result_q <= result_d;
      result_hi_q <= result_hi_d;
      n_q <= n_d;
      z_q <= z_d;
      c_q <= c_d;
      v_q <= v_d;
      err_q <= err_d;
    end
  end
  assign result = result_q;
  assign result_hi = result_hi_q;
  assign flag_n = n_q;
  assign flag_z = z_q;
  assign flag_c = c_q;
  assign flag_v = v_q;
  assign err = err_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
endmodule
